// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- frame controller for an oversampling UART receiver.
//
// Tracks the position inside a serial frame (start, data, optional parity,
// stop). Issues single-cycle enables to the start/parity/stop checkers and
// to the deserializer at the mid-bit check tick. Pulses data_valid when a
// frame completes without a parity or stop error.
//
// Ports
//   i_clk          oversampling clock, rising edge
//   i_rst          asynchronous, active-high reset
//   i_rx_in        serial line (idle high), already synchronised
//   i_par_en       frame carries a parity bit (latched at frame start)
//   i_prescale     oversampling ratio 8/16/32 (latched at frame start,
//                  any other value is treated as 8)
//   i_strt_glitch  registered start-bit glitch flag
//   i_par_err      registered parity error flag
//   i_stp_err      registered stop-bit error flag
//   o_edge_cnt     oversampling tick within the current bit
//   o_bit_cnt      bit index: 0 start, 1..DATA_WIDTH data, then parity, stop
//   o_dat_samp_en  sampler enable while a frame is in progress
//   o_strt_chk_en  start checker enable pulse
//   o_par_chk_en   parity checker enable pulse
//   o_stp_chk_en   stop checker enable pulse
//   o_deser_en     deserializer enable pulse (once per data bit)
//   o_data_valid   frame received without error (one cycle)
//   o_busy         high whenever the controller is not idle
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_in,
  input  logic       i_par_en,
  input  logic [5:0] i_prescale,
  input  logic       i_strt_glitch,
  input  logic       i_par_err,
  input  logic       i_stp_err,
  output logic [5:0] o_edge_cnt,
  output logic [3:0] o_bit_cnt,
  output logic       o_dat_samp_en,
  output logic       o_strt_chk_en,
  output logic       o_par_chk_en,
  output logic       o_stp_chk_en,
  output logic       o_deser_en,
  output logic       o_data_valid,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_LAST_DATA_BIT    = 4'(DATA_WIDTH);
  localparam logic [5:0] LP_DEFAULT_PRESCALE = 6'd8;

  state_t     r_state;
  state_t     w_next_state;
  logic [5:0] r_p_q;
  logic       r_par_en_q;
  logic       r_par_err_sticky;
  logic [5:0] r_edge_cnt;
  logic [3:0] r_bit_cnt;

  logic [5:0] w_prescale_legal;
  logic [5:0] w_chk_tick;
  logic [5:0] w_last_tick;
  logic       w_bit_end;
  logic       w_at_chk;
  logic       w_in_frame;
  logic       w_frame_start;

  // Mid-bit check tick: the sampler's majority vote is settled here.
  assign w_chk_tick    = (r_p_q >> 1) + 6'd2;
  assign w_last_tick   = r_p_q - 6'd1;
  assign w_bit_end     = (r_edge_cnt == w_last_tick);
  assign w_at_chk      = (r_edge_cnt == w_chk_tick);
  assign w_in_frame    = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);
  // A new frame starts from IDLE, or straight out of DONE for back-to-back frames.
  assign w_frame_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && !i_rx_in;

  always_comb begin
    case (i_prescale)
      6'd8, 6'd16, 6'd32: w_prescale_legal = i_prescale;
      default:            w_prescale_legal = LP_DEFAULT_PRESCALE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_next_state  = r_state;
    o_dat_samp_en = 1'b0;
    o_strt_chk_en = 1'b0;
    o_deser_en    = 1'b0;
    o_par_chk_en  = 1'b0;
    o_stp_chk_en  = 1'b0;
    o_data_valid  = 1'b0;
    o_busy        = (r_state != S_IDLE);
    o_edge_cnt    = r_edge_cnt;
    o_bit_cnt     = r_bit_cnt;
    case (r_state)
      S_IDLE: begin
        if (!i_rx_in) w_next_state = S_START;
      end
      S_START: begin
        o_dat_samp_en = 1'b1;
        o_strt_chk_en = w_at_chk;
        if (w_bit_end) w_next_state = i_strt_glitch ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        o_dat_samp_en = 1'b1;
        o_deser_en    = w_at_chk;
        if (w_bit_end && (r_bit_cnt == LP_LAST_DATA_BIT))
          w_next_state = r_par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        o_dat_samp_en = 1'b1;
        o_par_chk_en  = w_at_chk;
        if (w_bit_end) w_next_state = S_STOP;
      end
      S_STOP: begin
        o_dat_samp_en = 1'b1;
        o_stp_chk_en  = w_at_chk;
        if (w_bit_end) w_next_state = S_DONE;
      end
      S_DONE: begin
        o_data_valid = !r_par_err_sticky && !i_stp_err;
        w_next_state = i_rx_in ? S_IDLE : S_START;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p_q            <= LP_DEFAULT_PRESCALE;
      r_par_en_q       <= 1'b0;
      r_par_err_sticky <= 1'b0;
      r_edge_cnt       <= '0;
      r_bit_cnt        <= '0;
    end else if (w_frame_start) begin
      // Frame parameters are frozen here so mid-frame input changes are ignored.
      r_p_q            <= w_prescale_legal;
      r_par_en_q       <= i_par_en;
      r_par_err_sticky <= 1'b0;
      r_edge_cnt       <= '0;
      r_bit_cnt        <= '0;
    end else if (w_in_frame) begin
      if (w_bit_end) begin
        r_edge_cnt <= '0;
        // The index restarts after the stop bit or an aborted start bit,
        // so it never runs past the stop-bit index.
        if ((r_state == S_STOP) || (w_next_state == S_IDLE)) r_bit_cnt <= '0;
        else                                                 r_bit_cnt <= r_bit_cnt + 4'd1;
      end else begin
        r_edge_cnt <= r_edge_cnt + 6'd1;
      end
      // The parity flag is only meaningful while the parity bit is in flight.
      if ((r_state == S_PARITY) && i_par_err) r_par_err_sticky <= 1'b1;
    end else begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- self-checking bench for uart_rx_ctrl.
//
// A frame-level reference model derives the expected output vector of every
// cycle from the frame position (cycle index / effective prescale) and the
// frame options. Inputs are driven and outputs sampled on the falling edge.
module tb_uart_rx_ctrl;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic [5:0] prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       deser_en;
  logic       data_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_in      (rx_in),
    .i_par_en     (par_en),
    .i_prescale   (prescale),
    .i_strt_glitch(strt_glitch),
    .i_par_err    (par_err),
    .i_stp_err    (stp_err),
    .o_edge_cnt   (edge_cnt),
    .o_bit_cnt    (bit_cnt),
    .o_dat_samp_en(dat_samp_en),
    .o_strt_chk_en(strt_chk_en),
    .o_par_chk_en (par_chk_en),
    .o_stp_chk_en (stp_chk_en),
    .o_deser_en   (deser_en),
    .o_data_valid (data_valid),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // {busy, samp_en, strt, deser, par, stp, data_valid, bit_cnt, edge_cnt}
  function automatic logic [16:0] pack(input logic b, input logic s, input logic st,
                                       input logic de, input logic pa, input logic sp,
                                       input logic dv, input logic [3:0] bc,
                                       input logic [5:0] ec);
    return {b, s, st, de, pa, sp, dv, bc, ec};
  endfunction

  function automatic logic [16:0] observed();
    return pack(busy, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
                data_valid, bit_cnt, edge_cnt);
  endfunction

  function automatic int eff_prescale(input logic [5:0] p);
    return (p == 6'd8 || p == 6'd16 || p == 6'd32) ? int'(p) : 8;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    rx_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s idle%0d", tag, i), 32'(observed()), 32'd0);
    end
  endtask

  // Runs one frame starting at the current falling edge (DUT in IDLE or DONE).
  // abort_at >= 0 pulses reset in that frame cycle and returns to IDLE.
  task automatic run_frame(input string tag, input logic [5:0] presc,
                           input logic [5:0] presc_mid, input bit pe,
                           input logic [7:0] data, input bit glitch, input bit perr,
                           input bit serr, input bit b2b, input int abort_at);
    int p, chk, total, b, e, n_deser;
    logic [16:0] exp;
    p       = eff_prescale(presc);
    chk     = p / 2 + 2;
    total   = (glitch ? 1 : DW + 2 + int'(pe)) * p;
    n_deser = 0;
    rx_in = 1'b0; prescale = presc; par_en = pe;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      b = c / p;
      e = c % p;
      exp = pack(1'b1, 1'b1, b == 0 && e == chk, b >= 1 && b <= DW && e == chk,
                 pe && b == DW + 1 && e == chk, b == DW + 1 + int'(pe) && e == chk,
                 1'b0, 4'(b), 6'(e));
      check($sformatf("%s c=%0d", tag, c), 32'(observed()), 32'(exp));
      n_deser += int'(deser_en);
      if (c == abort_at) begin
        #1 rst = 1'b1;
        #1 check($sformatf("%s async_reset", tag), 32'(observed()), 32'd0);
        rx_in = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        @(negedge clk);
        check($sformatf("%s held_reset", tag), 32'(observed()), 32'd0);
        rst = 1'b0;
        return;
      end
      // Drive the rest of this cycle: serial level and registered checker flags.
      if (glitch)                rx_in = (c < 3) ? 1'b0 : 1'b1;
      else if (b == 0)           rx_in = 1'b0;
      else if (b <= DW)          rx_in = data[b-1];
      else if (pe && b == DW+1)  rx_in = ^data;
      else                       rx_in = 1'b1;
      if (c == 2 * p) prescale = presc_mid;
      strt_glitch = glitch && b == 0 && e > chk;
      par_err     = perr && b == DW + 1 && e > chk;
      stp_err     = serr && b == DW + 1 + int'(pe) && e > chk;
      if (c == total - 1) begin
        rx_in   = (b2b && !glitch) ? 1'b0 : 1'b1;
        stp_err = serr;
        par_err = 1'b0;
      end
    end
    @(negedge clk);
    if (glitch)
      exp = '0;
    else
      exp = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !(perr && pe) && !serr, 4'd0, 6'd0);
    check($sformatf("%s end", tag), 32'(observed()), 32'(exp));
    check($sformatf("%s deser_count", tag), 32'(n_deser), glitch ? 32'd0 : 32'(DW));
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
  endtask

  initial begin
    logic [5:0] ptab [6];
    logic [5:0] pr, pm;
    bit pe, perr, serr, gl, b2b;
    ptab[0] = 6'd8; ptab[1] = 6'd16; ptab[2] = 6'd32;
    ptab[3] = 6'd20; ptab[4] = 6'd0; ptab[5] = 6'd63;

    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    #2 check("reset_before_clock", 32'(observed()), 32'd0);
    rx_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_held_rx_low", 32'(observed()), 32'd0);
    rx_in = 1'b1;
    rst = 1'b0;
    idle_cycles("post_reset", 3);

    // Prescale 8, no parity, 0x55: 81-cycle latency, 8 deser pulses at tick 6.
    run_frame("p8_basic", 6'd8, 6'd8, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("p8_basic", 2);

    // Prescale 16 with parity error, then a clean frame.
    run_frame("p16_parerr", 6'd16, 6'd16, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    idle_cycles("p16_parerr", 2);
    run_frame("p16_clean", 6'd16, 6'd16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("p16_clean", 2);

    // Prescale 32 start glitch.
    run_frame("p32_glitch", 6'd32, 6'd32, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("p32_glitch", 3);

    // Back-to-back frames; the first carries a parity error, the second must not inherit it.
    run_frame("b2b_a", 6'd8, 6'd8, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    run_frame("b2b_b", 6'd16, 6'd16, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("b2b", 2);

    // Illegal prescale behaves as 8; mid-frame prescale changes are ignored.
    run_frame("p20_illegal", 6'd20, 6'd16, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("p20_illegal", 2);
    run_frame("p8_midchange", 6'd8, 6'd16, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("p8_midchange", 2);

    // Stop error suppresses data_valid.
    run_frame("p8_stperr", 6'd8, 6'd8, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle_cycles("p8_stperr", 2);

    // Reset during DATA at bit 4, then a normal frame.
    run_frame("abort", 6'd8, 6'd8, 1'b0, 8'hC5, 1'b0, 1'b0, 1'b0, 1'b0, 4 * 8 + 3);
    idle_cycles("abort", 4);
    run_frame("after_abort", 6'd8, 6'd8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_cycles("after_abort", 2);

    // Randomized frames.
    for (int i = 0; i < 10; i++) begin
      pr   = ptab[$urandom_range(0, 5)];
      pm   = ptab[$urandom_range(0, 5)];
      pe   = 1'($urandom_range(0, 1));
      perr = ($urandom_range(0, 2) == 0);
      serr = ($urandom_range(0, 3) == 0);
      gl   = ($urandom_range(0, 7) == 0);
      b2b  = (i != 9) && !gl && ($urandom_range(0, 1) == 1);
      run_frame($sformatf("rnd%0d", i), pr, pm, pe, 8'($urandom), gl, perr, serr, b2b, -1);
      if (!b2b) idle_cycles($sformatf("rnd%0d", i), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame, legal range 5..9.
REQ-002 CLK  input  1  receiver oversampling clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 RX_IN  input  1  serial line, idle high; already synchronised upstream.
REQ-005 PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-006 Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-007 strt_glitch / par_err / stp_err  input  1 each  registered flags from the start, parity and stop checkers.
REQ-008 edge_cnt  output  6  oversampling tick within the current bit, 0..Prescale-1.
REQ-009 bit_cnt  output  4  bit index within the frame: 0 = start, 1..DATA_WIDTH = data, then parity (if enabled), then stop.
REQ-010 dat_samp_en  output  1  enables the sampler while a frame is in progress.
REQ-011 strt_chk_en / par_chk_en / stp_chk_en / deser_en  output  1 each  single-cycle enable pulses to the checkers and the deserializer.
REQ-012 data_valid  output  1  single-cycle pulse; a frame was received without error.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP and DONE, held in registers.
REQ-015 Latched prescale: on the IDLE->START transition the block SHALL capture Prescale into P_q; an illegal value SHALL be captured as 8; changes to Prescale mid-frame SHALL be ignored.
REQ-016 Check point: CHK = P_q/2 + 2, the tick at which sampled_bit is valid.
REQ-017 IDLE: when RX_IN=0 is seen, the block SHALL move to START with edge_cnt=0 and bit_cnt=0.
REQ-018 edge_cnt SHALL increment each cycle in START, DATA, PARITY and STOP; on reaching P_q-1 it SHALL wrap to 0 and bit_cnt SHALL increment.
REQ-019 In the bit-owning state, exactly one enable pulse SHALL be issued when edge_cnt==CHK: strt_chk_en in START, deser_en in DATA, par_chk_en in PARITY, stp_chk_en in STOP.
REQ-020 START end (edge_cnt==P_q-1): if strt_glitch=1, the block SHALL go to IDLE with no data_valid; otherwise it SHALL go to DATA.
REQ-021 DATA end, after DATA_WIDTH bits: the block SHALL go to PARITY if PAR_EN=1, else to STOP; PAR_EN SHALL be latched on entry to START.
REQ-022 PARITY end: the block SHALL always go to STOP; the parity error SHALL be remembered in an internal sticky flag.
REQ-023 STOP end: the block SHALL go to DONE.
REQ-024 DONE lasts 1 cycle; data_valid SHALL be 1 iff par_err_sticky=0 and stp_err=0.
REQ-025 After DONE, the block SHALL go to START if RX_IN=0 (back-to-back frame, P_q re-latched), else to IDLE.
REQ-026 The sticky flag SHALL be cleared on entry to START.
REQ-027 In IDLE: edge_cnt=0, bit_cnt=0, dat_samp_en=0.
REQ-028 dat_samp_en SHALL be 1 in START through STOP inclusive.
REQ-029 No two enable pulses SHALL ever be asserted in the same cycle.
REQ-030 edge_cnt and bit_cnt SHALL never exceed P_q-1 and DATA_WIDTH+2 respectively.
REQ-031 Frame length from the falling edge seen in IDLE to the data_valid pulse: (DATA_WIDTH+2+PAR_EN)*P_q + 1 cycles.

Reset
REQ-032 While RST=1, the block SHALL be in IDLE with all outputs 0, P_q=8 and the sticky flag cleared, regardless of CLK.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately with no data_valid; after release, the block SHALL wait in IDLE for RX_IN=0.

Verification
REQ-034 Prescale=8, PAR_EN=0, frame 0x55, checker flags 0 -> deser_en pulses exactly 8 times at edge_cnt=6, data_valid=1 exactly 81 cycles after the start edge.
REQ-035 Prescale=16, PAR_EN=1, par_err=1 forced during PARITY -> block runs through STOP, data_valid stays 0, next frame (flags clean) gives data_valid=1.
REQ-036 Prescale=32, RX_IN low for 4 cycles and strt_glitch=1 -> return to IDLE at edge_cnt=31, no deser_en, busy falls.
REQ-037 Two back-to-back frames (RX_IN=0 in the DONE cycle) -> no IDLE cycle between them, two data_valid pulses.
REQ-038 Prescale=20 (illegal) -> timing identical to Prescale=8; Prescale changed to 16 mid-frame -> current frame unaffected.
REQ-039 RST pulsed during DATA at bit_cnt=4 -> all outputs 0 asynchronously, no data_valid, next frame received correctly.
